// File: rtl/responde_memoria_dados_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// parameter defaults and the request validity rule.
package responde_memoria_dados_pkg;

    localparam int unsigned LARGURA_DADO           = 8;
    localparam int unsigned LARGURA_ENDERECO       = 8;
    localparam int unsigned PROFUNDIDADE_PADRAO    = 32;
    localparam int unsigned ESPERAS_LEITURA_PADRAO = 1;
    localparam int unsigned LARGURA_ESPERA         = 3;

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        ACESSO   = 2'b01,
        ESPERA   = 2'b10,
        RESPOSTA = 2'b11
    } estado_t;

    // A request is malformed when it is neither exactly a read nor exactly
    // a write, or when it addresses a word beyond the array.
    function automatic logic pedido_invalido(
        input logic                        le,
        input logic                        escreve,
        input logic [LARGURA_ENDERECO-1:0] endereco,
        input int unsigned                 profundidade
    );
        logic [31:0] endereco_ext;
        endereco_ext = {{(32-LARGURA_ENDERECO){1'b0}}, endereco};
        return (le == escreve) || (endereco_ext >= profundidade);
    endfunction

endpackage

// File: rtl/responde_memoria_dados_banco.sv
// Word-addressed storage: synchronous write, combinational read and an
// asynchronous clear of every word while reset is held.
module banco_memoria_dados
    import responde_memoria_dados_pkg::*;
#(
    parameter int unsigned PROFUNDIDADE = PROFUNDIDADE_PADRAO
) (
    input  logic                        clock,
    input  logic                        Reset,
    input  logic                        escrita_en,
    input  logic [LARGURA_ENDERECO-1:0] end_escrita,
    input  logic [LARGURA_DADO-1:0]     dado_escrita,
    input  logic [LARGURA_ENDERECO-1:0] end_leitura,
    output logic [LARGURA_DADO-1:0]     dado_leitura
);

    logic [LARGURA_DADO-1:0] mem_q [PROFUNDIDADE];

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
                mem_q[i] <= '0;
            end
        end else if (escrita_en) begin
            for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
                if (end_escrita == LARGURA_ENDERECO'(i)) begin
                    mem_q[i] <= dado_escrita;
                end
            end
        end
    end

    // Out-of-range addresses read as zero; the FSM never uses them anyway.
    always_comb begin
        dado_leitura = '0;
        for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
            if (end_leitura == LARGURA_ENDERECO'(i)) begin
                dado_leitura = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/responde_memoria_dados.sv
// Data-memory responder: accepts one CPU load/store at a time, services it
// with a programmable read latency and holds the response until consumed.
module responde_memoria_dados
    import responde_memoria_dados_pkg::*;
#(
    parameter int unsigned PROFUNDIDADE    = PROFUNDIDADE_PADRAO,
    parameter int unsigned ESPERAS_LEITURA = ESPERAS_LEITURA_PADRAO
) (
    input  logic                        clock,
    input  logic                        Reset,
    input  logic                        pedido,
    input  logic                        le_mem,
    input  logic                        escreve_mem,
    input  logic [LARGURA_ENDERECO-1:0] endereco,
    input  logic [LARGURA_DADO-1:0]     dado_escrito,
    input  logic                        resp_aceito,
    output logic                        pronto,
    output logic                        resp_valido,
    output logic [LARGURA_DADO-1:0]     dado_lido,
    output logic                        erro,
    output logic [7:0]                  contador_acessos
);

    estado_t                     estado_q;
    logic [LARGURA_ENDERECO-1:0] endereco_q;
    logic [LARGURA_DADO-1:0]     dado_escrito_q;
    logic                        le_q;
    logic                        escreve_q;
    logic [LARGURA_ESPERA-1:0]   espera_q;
    logic                        pronto_q;
    logic                        resp_valido_q;
    logic                        erro_q;
    logic [LARGURA_DADO-1:0]     dado_lido_q;
    logic [7:0]                  acessos_q;
    logic [7:0]                  acessos_d;

    logic                        requisicao_erro;
    logic                        escrita_en;
    logic [LARGURA_DADO-1:0]     dado_mem;

    always_comb begin
        requisicao_erro = pedido_invalido(le_q, escreve_q, endereco_q, PROFUNDIDADE);
        escrita_en      = (estado_q == ACESSO) && !requisicao_erro && escreve_q;
        acessos_d       = acessos_q + 8'd1;
    end

    banco_memoria_dados #(
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_banco (
        .clock        (clock),
        .Reset        (Reset),
        .escrita_en   (escrita_en),
        .end_escrita  (endereco_q),
        .dado_escrita (dado_escrito_q),
        .end_leitura  (endereco_q),
        .dado_leitura (dado_mem)
    );

    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            estado_q       <= OCIOSO;
            endereco_q     <= '0;
            dado_escrito_q <= '0;
            le_q           <= 1'b0;
            escreve_q      <= 1'b0;
            espera_q       <= '0;
            pronto_q       <= 1'b1;
            resp_valido_q  <= 1'b0;
            erro_q         <= 1'b0;
            dado_lido_q    <= '0;
            acessos_q      <= '0;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                    if (pedido) begin
                        endereco_q     <= endereco;
                        dado_escrito_q <= dado_escrito;
                        le_q           <= le_mem;
                        escreve_q      <= escreve_mem;
                        pronto_q       <= 1'b0;
                        estado_q       <= ACESSO;
                    end
                end
                ACESSO: begin
                    if (requisicao_erro) begin
                        erro_q        <= 1'b1;
                        dado_lido_q   <= '0;
                        resp_valido_q <= 1'b1;
                        estado_q      <= RESPOSTA;
                    end else if (escreve_q) begin
                        erro_q        <= 1'b0;
                        resp_valido_q <= 1'b1;
                        estado_q      <= RESPOSTA;
                    end else begin
                        espera_q <= LARGURA_ESPERA'(ESPERAS_LEITURA);
                        estado_q <= ESPERA;
                    end
                end
                ESPERA: begin
                    // The edge that takes the counter from 1 to 0 is the one
                    // that captures the read data.
                    espera_q <= espera_q - 1'b1;
                    if (espera_q == LARGURA_ESPERA'(1)) begin
                        dado_lido_q   <= dado_mem;
                        erro_q        <= 1'b0;
                        resp_valido_q <= 1'b1;
                        estado_q      <= RESPOSTA;
                    end
                end
                RESPOSTA: begin
                    if (resp_aceito) begin
                        acessos_q     <= acessos_d;
                        resp_valido_q <= 1'b0;
                        pronto_q      <= 1'b1;
                        estado_q      <= OCIOSO;
                    end
                end
                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign pronto           = pronto_q;
    assign resp_valido      = resp_valido_q;
    assign dado_lido        = dado_lido_q;
    assign erro             = erro_q;
    assign contador_acessos = acessos_q;

endmodule

// File: tb/tb_responde_memoria_dados.sv
// Self-checking bench for responde_memoria_dados against a behavioural
// memory/counter model.
module tb_responde_memoria_dados;

    localparam int PROF = 32;
    localparam int ESP  = 1;

    logic       clock;
    logic       Reset;
    logic       pedido;
    logic       le_mem;
    logic       escreve_mem;
    logic [7:0] endereco;
    logic [7:0] dado_escrito;
    logic       resp_aceito;
    logic       pronto;
    logic       resp_valido;
    logic [7:0] dado_lido;
    logic       erro;
    logic [7:0] contador_acessos;

    logic [7:0] mem_m [256];
    logic [7:0] count_m;
    logic [7:0] last_dado;
    int         n_checks;
    int         n_fail;

    responde_memoria_dados #(
        .PROFUNDIDADE    (PROF),
        .ESPERAS_LEITURA (ESP)
    ) dut (
        .clock            (clock),
        .Reset            (Reset),
        .pedido           (pedido),
        .le_mem           (le_mem),
        .escreve_mem      (escreve_mem),
        .endereco         (endereco),
        .dado_escrito     (dado_escrito),
        .resp_aceito      (resp_aceito),
        .pronto           (pronto),
        .resp_valido      (resp_valido),
        .dado_lido        (dado_lido),
        .erro             (erro),
        .contador_acessos (contador_acessos)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
        count_m   = 8'h00;
        last_dado = 8'h00;
    endtask

    task automatic check_reset_outputs(input string nome);
        n_checks++;
        if (pronto !== 1'b1 || resp_valido !== 1'b0 || erro !== 1'b0 ||
            dado_lido !== 8'h00 || contador_acessos !== 8'h00) begin
            n_fail++;
            $display("FAIL %s: pronto=%b resp_valido=%b erro=%b dado_lido=%h contador=%h, required 1 0 0 00 00",
                     nome, pronto, resp_valido, erro, dado_lido, contador_acessos);
        end
    endtask

    // One complete transaction; called #1 after a rising edge or at a negedge.
    task automatic access(input logic le, input logic es, input logic [7:0] addr,
                          input logic [7:0] dado, input int hold);
        logic       exp_err;
        logic [7:0] exp_dado;
        int         exp_lat;
        int         lat;
        int         t;
        exp_err = (le == es) || (int'(addr) >= PROF);
        exp_lat = (!exp_err && le) ? 1 + ESP : 1;
        if (exp_err)  exp_dado = 8'h00;
        else if (le)  exp_dado = mem_m[addr];
        else          exp_dado = last_dado;

        t = 0;
        while (pronto !== 1'b1 && t < 50) begin
            @(posedge clock); #1; t++;
        end
        n_checks++;
        if (pronto !== 1'b1) begin
            n_fail++;
            $display("FAIL pronto_wait: pronto=%b, required 1", pronto);
        end

        pedido = 1'b1; le_mem = le; escreve_mem = es;
        endereco = addr; dado_escrito = dado;
        @(posedge clock); #1;
        pedido = 1'b0; le_mem = 1'b0; escreve_mem = 1'b0;
        endereco = $urandom; dado_escrito = $urandom;

        lat = 0;
        while (resp_valido !== 1'b1 && lat < 30) begin
            @(posedge clock); #1; lat++;
        end
        n_checks++;
        if (lat !== exp_lat || erro !== exp_err || dado_lido !== exp_dado || pronto !== 1'b0) begin
            n_fail++;
            $display("FAIL resposta addr=%0d le=%b es=%b: lat=%0d erro=%b dado=%h pronto=%b, required lat=%0d erro=%b dado=%h pronto=0",
                     addr, le, es, lat, erro, dado_lido, pronto, exp_lat, exp_err, exp_dado);
        end
        if (!exp_err && es) mem_m[addr] = dado;
        last_dado = exp_dado;

        for (int h = 0; h < hold; h++) begin
            @(posedge clock); #1;
            n_checks++;
            if (resp_valido !== 1'b1 || pronto !== 1'b0 || erro !== exp_err ||
                dado_lido !== exp_dado || contador_acessos !== count_m) begin
                n_fail++;
                $display("FAIL hold cycle %0d: valido=%b pronto=%b erro=%b dado=%h cont=%h, required 1 0 %b %h %h",
                         h, resp_valido, pronto, erro, dado_lido, contador_acessos, exp_err, exp_dado, count_m);
            end
        end

        resp_aceito = 1'b1;
        @(posedge clock); #1;
        resp_aceito = 1'b0;
        count_m = count_m + 8'd1;
        n_checks++;
        if (resp_valido !== 1'b0 || pronto !== 1'b1 || contador_acessos !== count_m) begin
            n_fail++;
            $display("FAIL consumo: valido=%b pronto=%b cont=%h, required 0 1 %h",
                     resp_valido, pronto, contador_acessos, count_m);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        pedido = 1'b0; le_mem = 1'b0; escreve_mem = 1'b0;
        endereco = 8'h00; dado_escrito = 8'h00; resp_aceito = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clock);
        Reset = 1'b0;
    endtask

    task automatic test_write_read();
        access(1'b0, 1'b1, 8'd3, 8'h5A, 0);
        access(1'b1, 1'b0, 8'd3, 8'h00, 0);
    endtask

    task automatic test_out_of_range();
        access(1'b1, 1'b0, 8'd40, 8'h00, 0);
        access(1'b0, 1'b1, 8'd40, 8'hC3, 0);
        access(1'b0, 1'b1, 8'd32, 8'hC4, 0);
        for (int a = 0; a < PROF; a++) access(1'b1, 1'b0, 8'(a), 8'h00, 0);
    endtask

    task automatic test_both_flags();
        access(1'b1, 1'b1, 8'd5, 8'hFF, 0);
        access(1'b0, 1'b0, 8'd6, 8'hEE, 0);
        access(1'b1, 1'b0, 8'd5, 8'h00, 0);
        access(1'b1, 1'b0, 8'd6, 8'h00, 0);
    endtask

    task automatic test_hold();
        access(1'b1, 1'b0, 8'd3, 8'h00, 5);
        access(1'b1, 1'b1, 8'd3, 8'h00, 5);
    endtask

    task automatic test_back_to_back();
        pedido = 1'b1; le_mem = 1'b0; escreve_mem = 1'b1;
        endereco = 8'd9; dado_escrito = 8'h33;
        @(posedge clock); #1;
        dado_escrito = 8'h44;
        @(posedge clock); #1;
        n_checks++;
        if (resp_valido !== 1'b1 || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first: valido=%b erro=%b, required 1 0", resp_valido, erro);
        end
        mem_m[9] = 8'h33;
        resp_aceito = 1'b1;
        @(posedge clock); #1;
        resp_aceito = 1'b0;
        count_m = count_m + 8'd1;
        n_checks++;
        if (pronto !== 1'b1 || contador_acessos !== count_m) begin
            n_fail++;
            $display("FAIL b2b_idle: pronto=%b cont=%h, required 1 %h", pronto, contador_acessos, count_m);
        end
        @(posedge clock); #1;
        pedido = 1'b0; escreve_mem = 1'b0;
        n_checks++;
        if (pronto !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_reaccept: pronto=%b, required 0", pronto);
        end
        @(posedge clock); #1;
        n_checks++;
        if (resp_valido !== 1'b1 || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: valido=%b erro=%b, required 1 0", resp_valido, erro);
        end
        mem_m[9] = 8'h44;
        resp_aceito = 1'b1;
        @(posedge clock); #1;
        resp_aceito = 1'b0;
        count_m = count_m + 8'd1;
        access(1'b1, 1'b0, 8'd9, 8'h00, 0);
    endtask

    task automatic test_reset_mid_wait();
        access(1'b0, 1'b1, 8'd7, 8'h11, 0);
        access(1'b1, 1'b0, 8'd7, 8'h00, 0);
        pedido = 1'b1; le_mem = 1'b1; escreve_mem = 1'b0; endereco = 8'd7;
        @(posedge clock); #1;
        pedido = 1'b0; le_mem = 1'b0;
        @(posedge clock); #1;
        Reset = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("reset_in_espera");
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset_held");
        @(negedge clock);
        Reset = 1'b0;
        access(1'b1, 1'b0, 8'd7, 8'h00, 0);
        access(1'b1, 1'b0, 8'd3, 8'h00, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 60; k++) begin
            access(1'($urandom), 1'($urandom), 8'($urandom_range(0, 39)),
                   8'($urandom), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_wrap();
        int guard;
        guard = 0;
        while (count_m != 8'h00 && guard < 300) begin
            access(1'($urandom), 1'($urandom), 8'($urandom_range(0, 35)), 8'($urandom), 0);
            guard++;
        end
        n_checks++;
        if (contador_acessos !== 8'h00) begin
            n_fail++;
            $display("FAIL wrap: contador=%h, required 00", contador_acessos);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_both_flags();
        test_hold();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
